// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, optional
// two's-complement operands, registered product held until the next completion.
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic [PW-1:0]   result_q, result_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    always_comb begin
        a_mag_c = (signed_mode && a_in[WIDTH-1]) ? (~a_in + WIDTH'(1)) : a_in;
        b_mag_c = (signed_mode && b_in[WIDTH-1]) ? (~b_in + WIDTH'(1)) : b_in;
    end

    // Next-state and datapath; the multiplicand shifts left so each step adds
    // it at the current bit weight.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = PW'(a_mag_c);
                    mplier_d = b_mag_c;
                    sign_d   = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = sign_q ? (~acc_q + PW'(1)) : acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: accepted operations push an expected
// product; a monitor pops and compares on every done strobe.
module tb_seq_multiplier;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;

    typedef struct {
        logic [PW-1:0] exp;
        int            acc_cyc;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          signed_mode = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic [PW-1:0] result;
    logic          ready;
    logic          done;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    txn_t exp_q[$];
    int   done_cyc[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_mode(signed_mode),
        .a_in       (a_in),
        .b_in       (b_in),
        .result     (result),
        .ready      (ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference: plain integer multiply of the operands interpreted per mode.
    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        longint ia = longint'(a);
        longint ib = longint'(b);
        longint p;
        if (s && a[W-1]) ia = ia - (longint'(1) << W);
        if (s && b[W-1]) ib = ib - (longint'(1) << W);
        p = ia * ib;
        return PW'(p);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Acceptance tracker: a start seen while ready is an accepted operation.
    always @(posedge clk) begin
        if (reset) exp_q.delete();
        else if (start && ready)
            exp_q.push_back('{exp: model(a_in, b_in, signed_mode), acc_cyc: cyc});
        cyc <= cyc + 1;
    end

    // Monitor: every done strobe must match the oldest outstanding operation.
    always @(negedge clk) begin
        txn_t t;
        if (done) begin
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                t = exp_q.pop_front();
                check("product", 64'(result), 64'(t.exp));
                check("ready_with_done", 64'(ready), 64'd1);
                check("latency", 64'(cyc - t.acc_cyc), 64'(W + 2));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !ready; i++) step();
        if (!ready) check("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        wait_ready();
        start = 1'b1;
        a_in = a;
        b_in = b;
        signed_mode = s;
        step();
        start = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        signed_mode = 1'($urandom);
        check("busy_after_accept", 64'(ready), 64'd0);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && ready) break;
            step();
        end
        if (i == 100) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n_done;

        // Reset for 3 edges, then idle with start low.
        repeat (3) step();
        reset = 1'b0;
        check("rst_result", 64'(result), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        repeat (6) step();
        check("idle_ready", 64'(ready), 64'd1);
        check("idle_done", 64'(done), 64'd0);

        // 11 x 9 unsigned, then hold for ten cycles.
        issue(4'd11, 4'd9, 1'b0);
        wait_idle();
        repeat (10) step();
        check("result_hold", 64'(result), 64'h63);

        // Signed corners and full-scale operands.
        issue(4'hD, 4'h5, 1'b1); wait_idle();
        check("neg3_x_5", 64'(result), 64'hF1);
        issue(4'h8, 4'h8, 1'b1); wait_idle();
        check("neg8_x_neg8", 64'(result), 64'h40);
        issue(4'h0, 4'h8, 1'b1); wait_idle();
        check("zero_x_neg8", 64'(result), 64'h00);
        issue(4'hF, 4'hF, 1'b0); wait_idle();
        check("u15_x_15", 64'(result), 64'hE1);
        issue(4'hF, 4'hF, 1'b1); wait_idle();
        check("neg1_x_neg1", 64'(result), 64'h01);

        // Start held through busy period and into the done cycle.
        done_cyc.delete();
        wait_ready();
        start = 1'b1;
        a_in = 4'd11;
        b_in = 4'd9;
        signed_mode = 1'b0;
        for (int k = 0; k < int'(W) + 3; k++) begin
            step();
            a_in = W'($urandom);
            b_in = W'($urandom);
            signed_mode = 1'($urandom);
        end
        start = 1'b0;
        wait_idle();
        check("b2b_done_count", 64'(done_cyc.size()), 64'd2);
        if (done_cyc.size() == 2)
            check("b2b_spacing", 64'(done_cyc[1] - done_cyc[0]), 64'(W + 2));

        // Abort two cycles into CALC.
        wait_ready();
        start = 1'b1;
        a_in = 4'd3;
        b_in = 4'd7;
        signed_mode = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        n_done = done_cyc.size();
        repeat (8) step();
        check("abort_no_strobe", 64'(done_cyc.size()), 64'(n_done));
        issue(4'd7, 4'd6, 1'b0); wait_idle();
        check("after_abort_7x6", 64'(result), 64'h2A);

        // Random operations with random gaps.
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                wait_idle();
                repeat ($urandom_range(0, 2)) step();
            end
        end
        wait_idle();
        repeat (3) step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier FSMD: the next generation of the team's 4-bit multiplier, generalised to any operand width and extended with a per-operation signed/unsigned mode and a one-cycle completion strobe. Accepts one operand pair per start/ready handshake, iterates one partial-product step per clock, and holds the full-width product until the next completion. Sits as a shared arithmetic unit behind a simple control FSM; no pipelining, one operation in flight.

## Interface
- WIDTH, 4, operand width in bits (≥2)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled with start
- a_in  input  WIDTH  multiplicand; sampled with start
- b_in  input  WIDTH  multiplier; sampled with start
- result  output  2*WIDTH  product register; two's complement when signed_mode was 1
- ready  output  1  1 = idle, start will be accepted
- done  output  1  one-cycle strobe: result has just been updated

## Operation
- States: IDLE, CALC, DONE.
- IDLE: ready=1. On edge with start=1: capture |a_in|, |b_in| (magnitudes if signed_mode=1, raw otherwise), capture sign = signed_mode & (a_in[MSB] ^ b_in[MSB]), clear accumulator (2*WIDTH bits), load step counter = WIDTH, go CALC.
- CALC: ready=0. Each edge: if multiplier LSB=1, accumulator += multiplicand shifted left by step index; shift multiplier right; decrement counter. After the WIDTH-th CALC edge go DONE.
- DONE: on the edge leaving DONE, result ← sign ? −accumulator : accumulator (2*WIDTH-bit two's complement), done ← 1, go IDLE.
- Width rules: all arithmetic in 2*WIDTH bits; no overflow possible (unsigned max (2^W−1)^2, signed max (−2^(W−1))^2 = 2^(2W−2) both fit). Magnitude of most-negative operand (e.g. 4'b1000) is 2^(W−1), represented correctly as unsigned WIDTH bits.
- Zero product is never negated to a nonzero value (−0 = 0).
- start, a_in, b_in, signed_mode ignored while ready=0; operands need not be held after acceptance.
- result holds its value between completions; unchanged by acceptance of a new start.

## Timing
- Reset (synchronous, at any edge with reset=1, including mid-CALC/DONE): state=IDLE, result=0, ready=1, done=0, accumulator/counter cleared; in-flight operation discarded, no done strobe.
- reset has priority over start on the same edge.
- Start accepted at edge E0 → ready=0 from E0; CALC occupies edges E0+1..E0+WIDTH; DONE edge E0+WIDTH+1 → done=1, result valid, ready=1 in the cycle after E0+WIDTH+1.
- Latency start-edge to done: WIDTH+1 clocks; throughput one product per WIDTH+2 clocks with back-to-back starts.
- done is high exactly one cycle; ready rises in the same cycle as done.
- start=1 during the done cycle is accepted (back-to-back); done falls and ready falls at that edge.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Reset held 3 cycles, then released → result=0, ready=1, done=0; start=0 keeps state IDLE indefinitely.
- WIDTH=4, unsigned 11×9 with 1-cycle start pulse → done exactly 5 clocks after start edge, result=8'h63 (99), ready=1 with done; result still 8'h63 ten cycles later.
- WIDTH=4, signed −3×5 (4'hD, 4'h5) → 8'hF1 (−15); signed −8×−8 (4'h8, 4'h8) → 8'h40 (64); signed 0×−8 → 8'h00.
- WIDTH=4, unsigned 15×15 → 8'hE1 (225); same operands signed (−1×−1) → 8'h01.
- Start asserted with new operands on every cycle while busy → ignored, first product unaffected; start held in done cycle → second product starts immediately, completes WIDTH+2 clocks after first done.
- Reset asserted 2 cycles into CALC → next cycle ready=1, done=0, result=0; no done strobe for aborted operation; fresh 7×6 afterward → 8'h2A.
